// File: rtl/sw_cmd_encoder.sv
// Switch front-end: sync, debounce and turn switch toggles into
// single-cycle set/del/add commands plus a held hex digit.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous reset, active low
//   sw     in   [7:0] raw switches: [3:0] hex, [4] add, [5] del, [6] set, [7] lock
//   sw_db  out  [7:0] debounced switch state
//   hex    out  [3:0] digit, updated when add issues, held until the next add
//   add    out  one-cycle pulse: append hex
//   del    out  one-cycle pulse: delete last digit
//   set    out  one-cycle pulse: commit value
//   ready  out  high once the initial settle period is over
module sw_cmd_encoder #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    output logic [7:0] sw_db,
    output logic [3:0] hex,
    output logic       add,
    output logic       del,
    output logic       set,
    output logic       ready
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [7:0]              meta_q, sync_q;
    logic [7:0]              sw_db_q, sw_db_d;
    logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
    logic [7:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                    pend_add_q, pend_add_d;
    logic                    pend_del_q, pend_del_d;
    logic                    pend_set_q, pend_set_d;
    logic [3:0]              hex_pend_q, hex_pend_d;
    logic [3:0]              hex_q, hex_d;
    logic                    add_q, add_d;
    logic                    del_q, del_d;
    logic                    set_q, set_d;
    logic [7:0]              acc;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sw_db_d    = sw_db_q;
        cnt_d      = cnt_q;
        pend_add_d = pend_add_q;
        pend_del_d = pend_del_q;
        pend_set_d = pend_set_q;
        hex_pend_d = hex_pend_q;
        hex_d      = hex_q;
        add_d      = 1'b0;
        del_d      = 1'b0;
        set_d      = 1'b0;
        acc        = '0;

        unique case (state_q)
            INIT: begin
                // Switches already up here are adopted silently.
                if (init_cnt_q == LAST) begin
                    sw_db_d    = sync_q;
                    init_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                for (int i = 0; i < 8; i++) begin
                    if (sync_q[i] == sw_db_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == LAST) begin
                        sw_db_d[i] = sync_q[i];
                        cnt_d[i]   = '0;
                        acc[i]     = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end

                // Issue from the flags as they stood before this edge.
                if (pend_set_q) begin
                    set_d      = 1'b1;
                    pend_set_d = 1'b0;
                end else if (pend_del_q) begin
                    del_d      = 1'b1;
                    pend_del_d = 1'b0;
                end else if (pend_add_q) begin
                    add_d      = 1'b1;
                    pend_add_d = 1'b0;
                    hex_d      = hex_pend_q;
                end

                // Toggles under lock only move sw_db.
                if (!sw_db_q[7]) begin
                    if (acc[6]) pend_set_d = 1'b1;
                    if (acc[5]) pend_del_d = 1'b1;
                    if (acc[4]) begin
                        pend_add_d = 1'b1;
                        hex_pend_d = sw_db_d[3:0];
                    end
                end

                if (acc[7] && sw_db_d[7]) begin
                    pend_add_d = 1'b0;
                    pend_del_d = 1'b0;
                    pend_set_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            meta_q     <= '0;
            sync_q     <= '0;
            sw_db_q    <= '0;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            pend_add_q <= 1'b0;
            pend_del_q <= 1'b0;
            pend_set_q <= 1'b0;
            hex_pend_q <= '0;
            hex_q      <= '0;
            add_q      <= 1'b0;
            del_q      <= 1'b0;
            set_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            meta_q     <= sw;
            sync_q     <= meta_q;
            sw_db_q    <= sw_db_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            pend_add_q <= pend_add_d;
            pend_del_q <= pend_del_d;
            pend_set_q <= pend_set_d;
            hex_pend_q <= hex_pend_d;
            hex_q      <= hex_d;
            add_q      <= add_d;
            del_q      <= del_d;
            set_q      <= set_d;
        end
    end

    assign sw_db = sw_db_q;
    assign hex   = hex_q;
    assign add   = add_q;
    assign del   = del_q;
    assign set   = set_q;
    assign ready = (state_q == RUN);

endmodule

// File: tb/tb_sw_cmd_encoder.sv
// Bench for sw_cmd_encoder: directed scenarios plus random switch
// activity, every cycle compared against a behavioural model.
module tb_sw_cmd_encoder;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] sw_db;
    logic [3:0] hex;
    logic       add, del, set, ready;

    sw_cmd_encoder #(
        .DB_CYCLES(DB),
        .CNT_W    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .sw_db(sw_db),
        .hex  (hex),
        .add  (add),
        .del  (del),
        .set  (set),
        .ready(ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_add = 0;
    int n_del = 0;
    int n_set = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state after each rising edge.
    logic [7:0] m_s1, m_s2, m_db;
    logic [3:0] m_hex, m_hexp;
    logic       m_add, m_del, m_set, m_run;
    logic       m_p_add, m_p_del, m_p_set;
    int         m_icnt;
    logic [7:0] hist[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_hex = '0; m_hexp = '0;
        m_add = 0; m_del = 0; m_set = 0; m_run = 0;
        m_p_add = 0; m_p_del = 0; m_p_set = 0;
        m_icnt = 0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic [7:0] seen, acc, old;
        logic       stable;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = sw;
        m_add = 0; m_del = 0; m_set = 0;
        if (!m_run) begin
            m_icnt++;
            if (m_icnt == DB) begin
                m_db  = seen;
                m_run = 1;
                hist.delete();
            end
            return;
        end
        // A bit is accepted once the last DB synced samples all differ.
        hist.push_back(seen);
        if (hist.size() > DB) void'(hist.pop_front());
        acc = '0;
        if (hist.size() == DB) begin
            for (int b = 0; b < 8; b++) begin
                stable = 1;
                foreach (hist[k]) if (hist[k][b] == m_db[b]) stable = 0;
                acc[b] = stable;
            end
        end
        old  = m_db;
        m_db = m_db ^ acc;
        if (m_p_set) begin
            m_set = 1; m_p_set = 0;
        end else if (m_p_del) begin
            m_del = 1; m_p_del = 0;
        end else if (m_p_add) begin
            m_add = 1; m_p_add = 0; m_hex = m_hexp;
        end
        if (!old[7]) begin
            if (acc[6]) m_p_set = 1;
            if (acc[5]) m_p_del = 1;
            if (acc[4]) begin
                m_p_add = 1;
                m_hexp  = m_db[3:0];
            end
        end
        if (acc[7] && m_db[7]) begin
            m_p_add = 0; m_p_del = 0; m_p_set = 0;
        end
    endtask

    task automatic check_all();
        chk("sw_db", {24'd0, sw_db}, {24'd0, m_db});
        chk("hex", {28'd0, hex}, {28'd0, m_hex});
        chk("add", {31'd0, add}, {31'd0, m_add});
        chk("del", {31'd0, del}, {31'd0, m_del});
        chk("set", {31'd0, set}, {31'd0, m_set});
        chk("ready", {31'd0, ready}, {31'd0, m_run});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        n_add += int'(add);
        n_del += int'(del);
        n_set += int'(set);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic tally_clr();
        n_add = 0; n_del = 0; n_set = 0;
    endtask

    initial begin
        // 1: switches up through reset and INIT never issue
        sw = 8'h15;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        cycn(2);
        rst_n = 1'b1;
        tally_clr();
        cycn(DB);
        chk("t1_ready", {31'd0, ready}, 32'd1);
        chk("t1_db", {24'd0, sw_db}, 32'h15);
        cycn(10);
        chk("t1_nocmd", n_add + n_del + n_set, 0);

        // 2: add with hex A, exact latency
        sw = 8'h1A;
        cycn(10);
        sw[4] = 1'b0;
        cycn(12);
        sw[4] = 1'b1;
        cycn(6);
        chk("t2_pre", {31'd0, add}, 32'd0);
        cyc();
        chk("t2_add", {31'd0, add}, 32'd1);
        chk("t2_hex", {28'd0, hex}, 32'hA);
        cyc();
        chk("t2_one", {31'd0, add}, 32'd0);
        chk("t2_hold", {28'd0, hex}, 32'hA);

        // 3: glitch on sw[5] rejected
        cycn(4);
        tally_clr();
        sw[5] = 1'b1;
        cycn(2);
        sw[5] = 1'b0;
        cycn(10);
        chk("t3_db5", {31'd0, sw_db[5]}, 32'd0);
        chk("t3_nodel", n_del, 0);

        // 4: simultaneous toggles issue set, del, add in order
        sw = sw ^ 8'h70;
        cycn(DB + 2);
        chk("t4_idle", {29'd0, set, del, add}, 32'b000);
        cyc();
        chk("t4_set", {29'd0, set, del, add}, 32'b100);
        cyc();
        chk("t4_del", {29'd0, set, del, add}, 32'b010);
        cyc();
        chk("t4_add", {29'd0, set, del, add}, 32'b001);
        cyc();
        chk("t4_end", {29'd0, set, del, add}, 32'b000);

        // 5: lock suppresses commands
        sw[7] = 1'b1;
        cycn(10);
        tally_clr();
        sw[6] = ~sw[6];
        cycn(10);
        chk("t5_follow", {31'd0, sw_db[6]}, {31'd0, sw[6]});
        chk("t5_noset", n_set, 0);
        sw[7] = 1'b0;
        cycn(10);
        tally_clr();
        sw[6] = ~sw[6];
        cycn(10);
        chk("t5_set", n_set, 1);

        // 6: reset during debounce drops the command
        sw[5] = ~sw[5];
        cycn(3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        cycn(2);
        rst_n = 1'b1;
        tally_clr();
        cycn(DB - 1);
        chk("t6_rdy", {31'd0, ready}, 32'd0);
        cycn(12);
        chk("t6_nodel", n_del, 0);

        // random switch activity with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) begin
                int b;
                b = int'($urandom_range(7));
                sw[b] = ~sw[b];
            end
            if ($urandom_range(699) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
